fifo_wr_arbiter: RTL and testbench

- Single-clock controller that owns one FIFO register-file memory: write data port Data_Width, combinational read, FIFO_DEPTH entries, Address-bit addresses.
- Shares the memory's single write port between NUM_REQ requesters using round-robin arbitration.
- Generates the memory's write enable, write address, write data and read address, and tracks occupancy (FULL/EMPTY/COUNT) for one reader.
- Sits between the producer blocks and the memory instance. At the top level the memory's W_CLK is tied to CLK and its active-low W_RST to ~RST.

---
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: owns the write and read pointers of one FIFO register-file
// memory and shares its single write port between NUM_REQ producers using
// round-robin arbitration. It also tracks occupancy for a single reader.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   REQ, REQ_DATA     per-requester write request and data (slice i = requester i)
//   GNT               one-hot grant; the memory write happens at the edge ending it
//   RD_EN             reader pop request (ignored while EMPTY)
//   FLUSH             synchronous clear of pointers and occupancy
//   MEM_W_CKEN        memory write enable
//   MEM_WR_ADDR/DATA  memory write address/data (data is 0 with no grant)
//   MEM_RD_ADDR       memory read address; the reader samples RD_DATA directly
//   FULL, EMPTY       occupancy flags decoded from registered COUNT
//   COUNT             number of stored entries
//
// Optional feature (macro FIFO_WR_ARB_WATERMARK_EN): adds parameters AF_LEVEL and
// AE_LEVEL, and outputs ALMOST_FULL (COUNT >= AF_LEVEL) and
// ALMOST_EMPTY (COUNT <= AE_LEVEL).
module fifo_wr_arbiter #(
   parameter int unsigned Data_Width = 8,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned Address    = 3,
   parameter int unsigned NUM_REQ    = 4
`ifdef FIFO_WR_ARB_WATERMARK_EN
   , parameter int unsigned AF_LEVEL = FIFO_DEPTH - 2
   , parameter int unsigned AE_LEVEL = 2
`endif
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            REQ,
   input  logic [NUM_REQ*Data_Width-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]            GNT,
   input  logic                          RD_EN,
   input  logic                          FLUSH,
   output logic                          MEM_W_CKEN,
   output logic [Address-1:0]            MEM_WR_ADDR,
   output logic [Data_Width-1:0]         MEM_WR_DATA,
   output logic [Address-1:0]            MEM_RD_ADDR,
   output logic                          FULL,
   output logic                          EMPTY,
   output logic [Address:0]              COUNT
`ifdef FIFO_WR_ARB_WATERMARK_EN
   , output logic                        ALMOST_FULL
   , output logic                        ALMOST_EMPTY
`endif
);

   localparam int unsigned PP_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = Address + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [PP_W-1:0]  LAST_REQ = PP_W'(NUM_REQ - 1);

   logic [Address-1:0] wr_ptr;
   logic [Address-1:0] rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [PP_W-1:0]    pp;

   logic               arb_en;
   logic               found;
   logic [PP_W-1:0]    gnt_idx;
   int unsigned        cand;
   logic               push;
   logic               pop;

   // Round-robin search starting at pp; first active requester wins.
   always_comb begin
      GNT     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      arb_en  = !RST && !FLUSH && !FULL;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(pp) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (arb_en && !found && REQ[cand[PP_W-1:0]]) begin
            found   = 1'b1;
            gnt_idx = cand[PP_W-1:0];
         end
      end
      if (found) GNT[gnt_idx] = 1'b1;
   end

   // Write-data mux; zero when nobody is granted.
   always_comb begin
      MEM_WR_DATA = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (GNT[i]) MEM_WR_DATA = REQ_DATA[i*Data_Width +: Data_Width];
      end
   end

   // A pop needs stored data at the edge; a same-cycle push does not count.
   assign push = found;
   assign pop  = RD_EN && !EMPTY && !FLUSH;

   // Pointer, occupancy and priority-pointer state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         pp     <= '0;
      end else if (FLUSH) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            pp     <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign MEM_W_CKEN  = push;
   assign MEM_WR_ADDR = wr_ptr;
   assign MEM_RD_ADDR = rd_ptr;
   assign COUNT       = count;
   assign FULL        = (count == DEPTH_C);
   assign EMPTY       = (count == '0);

`ifdef FIFO_WR_ARB_WATERMARK_EN
   localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_LEVEL);

   assign ALMOST_FULL  = (count >= AF_C);
   assign ALMOST_EMPTY = (count <= AE_C);
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter with a behavioural register-file memory.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        rd_en;
   logic        flush;
   logic        mem_w_cken;
   logic [2:0]  mem_wr_addr;
   logic [7:0]  mem_wr_data;
   logic [2:0]  mem_rd_addr;
   logic        full;
   logic        empty;
   logic [3:0]  count;
`ifdef FIFO_WR_ARB_WATERMARK_EN
   logic        almost_full;
   logic        almost_empty;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem [0:7];
   logic [7:0] rd_data;
   logic [7:0] dat [0:3];

   fifo_wr_arbiter dut (
      .CLK          (clk),
      .RST          (rst),
      .REQ          (req),
      .REQ_DATA     (req_data),
      .GNT          (gnt),
      .RD_EN        (rd_en),
      .FLUSH        (flush),
      .MEM_W_CKEN   (mem_w_cken),
      .MEM_WR_ADDR  (mem_wr_addr),
      .MEM_WR_DATA  (mem_wr_data),
      .MEM_RD_ADDR  (mem_rd_addr),
      .FULL         (full),
      .EMPTY        (empty),
      .COUNT        (count)
`ifdef FIFO_WR_ARB_WATERMARK_EN
      , .ALMOST_FULL  (almost_full)
      , .ALMOST_EMPTY (almost_empty)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory instance stand-in: synchronous write, combinational read.
   always @(posedge clk) if (mem_w_cken) mem[mem_wr_addr] <= mem_wr_data;
   assign rd_data = mem[mem_rd_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      dat[0] = 8'hA0; dat[1] = 8'hA1; dat[2] = 8'hA2; dat[3] = 8'hA3;
      req_data = {dat[3], dat[2], dat[1], dat[0]};
      rst = 1'b1; req = 4'b1111; rd_en = 1'b0; flush = 1'b0;

      // Reset: no grant while RST is high, state cleared.
      #1;
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_cken", 32'(mem_w_cken), 32'h0);
      tick(); tick();
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
      check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);

      // Fill with all four requesting: strict rotation 0,1,2,3,0,...
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("fill_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
         check("fill_wr_addr", 32'(mem_wr_addr), 32'(i));
         check("fill_wr_data", 32'(mem_wr_data), 32'(dat[i % 4]));
         tick();
      end
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd8);
      #1;
      check("full_gnt", 32'(gnt), 32'h0);
      check("full_cken", 32'(mem_w_cken), 32'h0);
      check("full_wr_data", 32'(mem_wr_data), 32'h0);

      // Drain: data returns in write order.
      req = 4'b0000; rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("drain_rd_addr", 32'(mem_rd_addr), 32'(i));
         check("drain_data", 32'(rd_data), 32'(dat[i % 4]));
         tick();
      end
      rd_en = 1'b0;
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_count", 32'(count), 32'd0);

      // Single requester gets back-to-back grants; pp ends at 3.
      req = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("solo_gnt", 32'(gnt), 32'h4);
         tick();
      end
      check("solo_count", 32'(count), 32'd3);
      req = 4'b0101;
      #1;
      check("wrap_gnt0", 32'(gnt), 32'h1);
      tick();
      req = 4'b0100;
      #1;
      check("wrap_gnt2", 32'(gnt), 32'h4);
      tick();
      check("wrap_count", 32'(count), 32'd5);

      // Push and pop together: count holds, pp moves to 2.
      req = 4'b0010; rd_en = 1'b1;
      #1;
      check("pp_gnt1", 32'(gnt), 32'h2);
      check("pp_rd_data", 32'(rd_data), 32'(dat[2]));
      tick();
      check("pp_count", 32'(count), 32'd5);
      check("pp_rd_addr", 32'(mem_rd_addr), 32'd1);
      check("pp_wr_addr", 32'(mem_wr_addr), 32'd6);

      // Flush suppresses grant and pop, clears pointers, keeps pp.
      req = 4'b1111; flush = 1'b1;
      #1;
      check("flush_gnt", 32'(gnt), 32'h0);
      check("flush_cken", 32'(mem_w_cken), 32'h0);
      tick();
      flush = 1'b0; rd_en = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_wr_addr", 32'(mem_wr_addr), 32'd0);
      check("flush_rd_addr", 32'(mem_rd_addr), 32'd0);
      check("flush_empty", 32'(empty), 32'd1);
      #1;
      check("post_flush_gnt", 32'(gnt), 32'h4);
      tick();
      check("post_flush_count", 32'(count), 32'd1);

      // Clean flush (pp=3), then fill to 8 with all requesting.
      req = 4'b0000; flush = 1'b1;
      tick();
      flush = 1'b0; req = 4'b1111;
      #1;
      check("refill_first_gnt", 32'(gnt), 32'h8);
      for (int i = 0; i < 8; i++) tick();
      check("refill_count", 32'(count), 32'd8);

      // FULL blocks grant even with a same-cycle pop.
      req = 4'b0001; rd_en = 1'b1;
      #1;
      check("fullpop_gnt", 32'(gnt), 32'h0);
      tick();
      rd_en = 1'b0;
      check("fullpop_count", 32'(count), 32'd7);
      #1;
      check("wrap_wr_gnt", 32'(gnt), 32'h1);
      check("wrap_wr_addr", 32'(mem_wr_addr), 32'd0);
      tick();
      check("wrap_wr_count", 32'(count), 32'd8);
      check("wrap_wr_full", 32'(full), 32'd1);
      check("wrap_mem0", 32'(mem[0]), 32'(dat[0]));

      // Empty FIFO: push with RD_EN gives COUNT=1 without moving rd_ptr.
      req = 4'b0000; flush = 1'b1;
      tick();
      flush = 1'b0; req = 4'b0010; rd_en = 1'b1;
      #1;
      check("emp_gnt", 32'(gnt), 32'h2);
      tick();
      check("emp_count", 32'(count), 32'd1);
      check("emp_rd_addr", 32'(mem_rd_addr), 32'd0);
      check("emp_empty", 32'(empty), 32'd0);
      req = 4'b0000;
      tick();
      check("emp_pop_count", 32'(count), 32'd0);
      check("emp_pop_rd_addr", 32'(mem_rd_addr), 32'd1);
      tick();
      rd_en = 1'b0;
      check("emp_ignore_count", 32'(count), 32'd0);
      check("emp_ignore_rd_addr", 32'(mem_rd_addr), 32'd1);

      // Occupancy sweep 0..8 with one requester held, then reset mid-fill.
      req = 4'b0000; flush = 1'b1;
      tick();
      flush = 1'b0; req = 4'b0001;
      for (int c = 0; c <= 8; c++) begin
         check("sweep_count", 32'(count), 32'(c));
         check("sweep_full", 32'(full), 32'(c == 8));
         check("sweep_empty", 32'(empty), 32'(c == 0));
`ifdef FIFO_WR_ARB_WATERMARK_EN
         check("sweep_ae", 32'(almost_empty), 32'(c <= 2));
         check("sweep_af", 32'(almost_full), 32'(c >= 6));
`endif
         if (c == 4) break;
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; req = 4'b0000;
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_empty", 32'(empty), 32'd1);
      check("midrst_wr_addr", 32'(mem_wr_addr), 32'd0);
`ifdef FIFO_WR_ARB_WATERMARK_EN
      check("midrst_ae", 32'(almost_empty), 32'd1);
      check("midrst_af", 32'(almost_full), 32'd0);
`endif
      // After reset pp=0: requesters 3 and 0 contend, 0 wins.
      req = 4'b1001;
      #1;
      check("midrst_pp_gnt", 32'(gnt), 32'h1);
      tick();
      req = 4'b0001;
      for (int c = 1; c <= 8; c++) begin
         check("sweep2_count", 32'(count), 32'(c));
`ifdef FIFO_WR_ARB_WATERMARK_EN
         check("sweep2_ae", 32'(almost_empty), 32'(c <= 2));
         check("sweep2_af", 32'(almost_full), 32'(c >= 6));
`endif
         if (c < 8) tick();
      end
      check("sweep2_full", 32'(full), 32'd1);
      req = 4'b0000;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
